// File: rtl/frogger_pkg.sv
// Shared Frogger types: keycodes, sprite orientation and frog life-cycle states.
// Latency: none; this file holds declarations and pure functions only.
// Backpressure: not applicable.
package frogger_pkg;

  localparam logic [7:0] KEY_W = 8'h1A;
  localparam logic [7:0] KEY_A = 8'h04;
  localparam logic [7:0] KEY_S = 8'h16;
  localparam logic [7:0] KEY_D = 8'h07;

  typedef enum logic [1:0] {UP = 2'd0, LEFT = 2'd1, DOWN = 2'd2, RIGHT = 2'd3} dir_t;

  typedef enum logic [1:0] {IDLE = 2'd0, HOP = 2'd1, DEAD = 2'd2, OVER = 2'd3} frog_state_t;

  // True for the four movement keys; everything else (including 0x00) is ignored.
  function automatic logic key_is_move(input logic [7:0] k);
    return (k == KEY_W) || (k == KEY_A) || (k == KEY_S) || (k == KEY_D);
  endfunction

  // Only meaningful when key_is_move(k) holds.
  function automatic dir_t key_to_dir(input logic [7:0] k);
    case (k)
      KEY_W:   return UP;
      KEY_A:   return LEFT;
      KEY_S:   return DOWN;
      default: return RIGHT;
    endcase
  endfunction

endpackage

// File: rtl/frog_motion_if.sv
// Bundle between game logic / renderer and the frog controller.
// Latency: none; plain wires.
// Backpressure: none; keycode/hit/restart are level or pulse inputs.
interface frog_motion_if;
  logic [7:0] keycode;
  logic       hit;
  logic       restart;
  logic [9:0] BallX;
  logic [9:0] BallY;
  logic [1:0] frog_dir;
  logic       hopping;
  logic       dead;
  logic       game_over;
  logic [1:0] lives;
  logic [7:0] score;

  modport master (
    output keycode, hit, restart,
    input  BallX, BallY, frog_dir, hopping, dead, game_over, lives, score
  );

  modport slave (
    input  keycode, hit, restart,
    output BallX, BallY, frog_dir, hopping, dead, game_over, lives, score
  );
endinterface

// File: rtl/frame_tick_sync.sv
// Brings frame_clk into the Clk domain and emits a one-cycle tick per rising edge.
// Latency: tick is high 3 Clk cycles after the frame_clk rise (2 sync flops + registered edge).
// Backpressure: none; a tick is never held or queued.
module frame_tick_sync (
  input  logic Clk,
  input  logic Reset_n,
  input  logic frame_clk,
  output logic tick
);

  logic meta_q, sync_q, prev_q, tick_q;
  logic tick_d;

  assign tick_d = sync_q & ~prev_q;

  // Two-flop synchronizer, delayed copy for edge detection, registered tick.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      meta_q <= frame_clk;
      sync_q <= meta_q;
      prev_q <= sync_q;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/frog_motion.sv
// Frog position/life controller: keycodes become animated tile hops, with death, respawn and scoring.
// Latency: outputs change on the Clk edge after a frame tick; restart acts on the next Clk edge.
// Backpressure: one pending key slot; presses outside IDLE are dropped, held keys do not repeat.
module frog_motion
  import frogger_pkg::*;
#(
  parameter int START_X      = 312,
  parameter int START_Y      = 464,
  parameter int STEP         = 16,
  parameter int HOP_FRAMES   = 4,
  parameter int X_MAX        = 623,
  parameter int Y_MAX        = 464,
  parameter int DEATH_FRAMES = 30,
  parameter int LIVES        = 3
) (
  input  logic           Clk,
  input  logic           Reset_n,
  input  logic           frame_clk,
  frog_motion_if.slave   bus
);

  localparam logic [9:0]  START_X_C = 10'(START_X);
  localparam logic [9:0]  START_Y_C = 10'(START_Y);
  localparam logic [9:0]  HOP_PX    = 10'(STEP / HOP_FRAMES);
  localparam logic [10:0] STEP_W    = 11'(STEP);
  localparam logic [10:0] X_MAX_W   = 11'(X_MAX);
  localparam logic [10:0] Y_MAX_W   = 11'(Y_MAX);
  localparam logic [7:0]  HOP_LAST  = 8'(HOP_FRAMES - 1);
  localparam logic [7:0]  DEATH_LAST = 8'(DEATH_FRAMES - 1);
  localparam logic [1:0]  LIVES_C   = 2'(LIVES);

  logic        tick;
  frog_state_t state_q, state_d;
  logic [9:0]  x_q, x_d, y_q, y_d;
  dir_t        dir_q, dir_d;
  logic [1:0]  lives_q, lives_d;
  logic [7:0]  score_q, score_d;
  logic [7:0]  hop_cnt_q, hop_cnt_d;
  logic [7:0]  death_cnt_q, death_cnt_d;
  logic        pend_vld_q, pend_vld_d;
  dir_t        pend_dir_q, pend_dir_d;
  logic [7:0]  key_prev_q;
  logic        press;
  dir_t        mv_dir;
  logic [9:0]  mv_x, mv_y;
  logic        tgt_ok;

  frame_tick_sync u_tick (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .frame_clk (frame_clk),
    .tick      (tick)
  );

  assign press = key_is_move(bus.keycode) && (bus.keycode != key_prev_q);

  // One animation step in the active direction, plus whether the full tile hop stays on the playfield.
  always_comb begin
    mv_dir = (state_q == IDLE) ? pend_dir_q : dir_q;
    mv_x   = x_q;
    mv_y   = y_q;
    tgt_ok = 1'b0;
    case (mv_dir)
      UP:    begin mv_y = y_q - HOP_PX; tgt_ok = {1'b0, y_q} >= STEP_W; end
      LEFT:  begin mv_x = x_q - HOP_PX; tgt_ok = {1'b0, x_q} >= STEP_W; end
      DOWN:  begin mv_y = y_q + HOP_PX; tgt_ok = ({1'b0, y_q} + STEP_W) <= Y_MAX_W; end
      RIGHT: begin mv_x = x_q + HOP_PX; tgt_ok = ({1'b0, x_q} + STEP_W) <= X_MAX_W; end
      default: ;
    endcase
  end

  // Next-state: restart from OVER, otherwise per-tick motion/death, then key capture.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    dir_d       = dir_q;
    lives_d     = lives_q;
    score_d     = score_q;
    hop_cnt_d   = hop_cnt_q;
    death_cnt_d = death_cnt_q;
    pend_vld_d  = pend_vld_q;
    pend_dir_d  = pend_dir_q;

    if (bus.restart && (state_q == OVER)) begin
      state_d     = IDLE;
      x_d         = START_X_C;
      y_d         = START_Y_C;
      dir_d       = UP;
      lives_d     = LIVES_C;
      score_d     = 8'd0;
      hop_cnt_d   = 8'd0;
      death_cnt_d = 8'd0;
      pend_vld_d  = 1'b0;
      pend_dir_d  = UP;
    end else if (tick) begin
      if (bus.hit && ((state_q == IDLE) || (state_q == HOP))) begin
        // Collision wins over movement: position freezes where it is.
        lives_d    = lives_q - 2'd1;
        pend_vld_d = 1'b0;
        if (lives_q == 2'd1) begin
          state_d = OVER;
        end else begin
          state_d     = DEAD;
          death_cnt_d = DEATH_LAST;
        end
      end else begin
        case (state_q)
          IDLE: begin
            if (pend_vld_q) begin
              dir_d      = pend_dir_q;
              pend_vld_d = 1'b0;
              if (tgt_ok) begin
                state_d   = HOP;
                hop_cnt_d = HOP_LAST;
                x_d       = mv_x;
                y_d       = mv_y;
              end
            end
          end
          HOP: begin
            if (hop_cnt_q == 8'd0) begin
              state_d = IDLE;
              if (y_q == 10'd0) begin
                score_d = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
                x_d     = START_X_C;
                y_d     = START_Y_C;
              end
            end else begin
              hop_cnt_d = hop_cnt_q - 8'd1;
              x_d       = mv_x;
              y_d       = mv_y;
            end
          end
          DEAD: begin
            if (death_cnt_q == 8'd0) begin
              state_d = IDLE;
              x_d     = START_X_C;
              y_d     = START_Y_C;
              dir_d   = UP;
            end else begin
              death_cnt_d = death_cnt_q - 8'd1;
            end
          end
          default: ;
        endcase
      end
    end

    // A press landing on a tick cycle survives the tick's consumption and is used next frame.
    if (press && (state_q == IDLE)) begin
      pend_vld_d = 1'b1;
      pend_dir_d = key_to_dir(bus.keycode);
    end
  end

  // State and datapath registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      x_q         <= START_X_C;
      y_q         <= START_Y_C;
      dir_q       <= UP;
      lives_q     <= LIVES_C;
      score_q     <= 8'd0;
      hop_cnt_q   <= 8'd0;
      death_cnt_q <= 8'd0;
      pend_vld_q  <= 1'b0;
      pend_dir_q  <= UP;
      key_prev_q  <= 8'd0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      dir_q       <= dir_d;
      lives_q     <= lives_d;
      score_q     <= score_d;
      hop_cnt_q   <= hop_cnt_d;
      death_cnt_q <= death_cnt_d;
      pend_vld_q  <= pend_vld_d;
      pend_dir_q  <= pend_dir_d;
      key_prev_q  <= bus.keycode;
    end
  end

  assign bus.BallX     = x_q;
  assign bus.BallY     = y_q;
  assign bus.frog_dir  = dir_q;
  assign bus.hopping   = (state_q == HOP);
  assign bus.dead      = (state_q == DEAD);
  assign bus.game_over = (state_q == OVER);
  assign bus.lives     = lives_q;
  assign bus.score     = score_q;

endmodule
